// File: rtl/demux_param_reg_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer: default sizes
// and the per-lane next-state operation decode.
package demux_param_reg_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 4;

    typedef enum logic [1:0] {
        LANE_HOLD  = 2'b00,
        LANE_DRAIN = 2'b01,
        LANE_LOAD  = 2'b10,
        LANE_SWAP  = 2'b11
    } lane_op_e;

    // A swap is a drain and a load on the same edge; the lane stays full.
    function automatic lane_op_e lane_op(input logic load, input logic drain);
        lane_op_e op;
        case ({load, drain})
            2'b10:   op = LANE_LOAD;
            2'b01:   op = LANE_DRAIN;
            2'b11:   op = LANE_SWAP;
            default: op = LANE_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/demux_param_reg_lane.sv
// One-entry holding register for a single output lane of demux_param_reg.
// Data keeps its last value when the lane drains without a reload.
module demux_param_reg_lane
    import demux_param_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lane_data,
    output logic             lane_vld
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             vld_q;
    logic             vld_d;
    logic             drain;

    assign drain = vld_q & out_ready;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        case (lane_op(load, drain))
            LANE_LOAD, LANE_SWAP: begin
                data_d = load_data;
                vld_d  = 1'b1;
            end
            LANE_DRAIN: vld_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign lane_data = data_q;
    assign lane_vld  = vld_q;

endmodule

// File: rtl/demux_param_reg.sv
// Registered 1-to-N demultiplexer with valid/ready flow control: steers each
// accepted input beat into the holding register of the lane picked by in_sel.
module demux_param_reg
    import demux_param_reg_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = DEFAULT_N,
    localparam int SELW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data [N-1:0],
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic             busy
);

    logic [N-1:0] sel_hit;
    logic [N-1:0] lane_load;
    logic         accept;

    // Select values at or above N match no lane, so in_ready stays low for them.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < N; i++) begin
            sel_hit[i] = (in_sel == SELW'(i));
        end
    end

    assign in_ready  = |(sel_hit & (~out_valid | out_ready));
    assign accept    = in_valid & in_ready;
    assign lane_load = sel_hit & {N{accept}};
    assign busy      = |out_valid;

    for (genvar g = 0; g < N; g++) begin : g_lane
        demux_param_reg_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (lane_load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .lane_data (out_data[g]),
            .lane_vld  (out_valid[g])
        );
    end

endmodule

// File: tb/tb_demux_param_reg.sv
// Directed self-checking bench for demux_param_reg: a default N=4 instance for
// routing/backpressure/reset, and an N=3 instance for illegal-select handling.
module tb_demux_param_reg;

    logic        clk;
    logic        rst_n;

    logic [31:0] a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_out_data [3:0];
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic        a_busy;

    logic [31:0] b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_out_data [2:0];
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_busy;

    int total;
    int bad;

    demux_param_reg #(.WIDTH(32), .N(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .busy      (a_busy)
    );

    demux_param_reg #(.WIDTH(32), .N(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source must hold a stalled beat steady on the N=4 instance.
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [1:0]  prev_sel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && a_in_valid) begin
                assert (a_in_data == prev_data && a_in_sel == prev_sel)
                    else $error("[TB] source changed a stalled beat");
            end
            prev_stall <= a_in_valid & ~a_in_ready;
            prev_data  <= a_in_data;
            prev_sel   <= a_in_sel;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] data);
        a_in_sel   = sel;
        a_in_data  = data;
        a_in_valid = 1'b1;
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_in_sel    = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 4'b0000;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 3'b000;

        tick();
        tick();
        checkOutput("reset_valid", 32'(a_out_valid), 32'h0);
        checkOutput("reset_busy", 32'(a_busy), 32'h0);
        checkOutput("reset_data0", a_out_data[0], 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic routing, all lanes ready
        a_out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k), 32'hA0 + 32'(k));
            checkOutput("route_ready", 32'(a_in_ready), 32'h1);
            tick();
            checkOutput("route_valid", 32'(a_out_valid), 32'h1 << k);
            checkOutput("route_data", a_out_data[k], 32'hA0 + 32'(k));
            checkOutput("route_busy", 32'(a_busy), 32'h1);
        end
        a_in_valid = 1'b0;
        tick();
        checkOutput("route_idle", 32'(a_out_valid), 32'h0);
        checkOutput("route_idle_busy", 32'(a_busy), 32'h0);

        // Backpressure on lane 1
        a_out_ready = 4'b1101;
        applyStimulus(2'd1, 32'h11);
        checkOutput("bp_first_ready", 32'(a_in_ready), 32'h1);
        tick();
        applyStimulus(2'd1, 32'h22);
        checkOutput("bp_stall_ready", 32'(a_in_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("bp_hold_data", a_out_data[1], 32'h11);
            checkOutput("bp_hold_valid", 32'(a_out_valid), 32'h2);
            checkOutput("bp_hold_ready", 32'(a_in_ready), 32'h0);
        end
        a_out_ready = 4'b1111;
        #1;
        checkOutput("bp_release_ready", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("bp_second_data", a_out_data[1], 32'h22);
        checkOutput("bp_second_valid", 32'(a_out_valid), 32'h2);
        a_in_valid = 1'b0;
        tick();
        checkOutput("bp_drained", 32'(a_out_valid), 32'h0);
        checkOutput("bp_data_kept", a_out_data[1], 32'h22);

        // Simultaneous drain and load on lane 3
        a_out_ready = 4'b0111;
        applyStimulus(2'd3, 32'h33);
        tick();
        checkOutput("swap_first", a_out_data[3], 32'h33);
        a_out_ready = 4'b1111;
        applyStimulus(2'd3, 32'h44);
        checkOutput("swap_ready", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("swap_valid", 32'(a_out_valid), 32'h8);
        checkOutput("swap_data", a_out_data[3], 32'h44);
        a_in_valid = 1'b0;
        tick();
        checkOutput("swap_drained", 32'(a_out_valid), 32'h0);

        // Lane isolation: lane 0 stalled full, stream into lane 2
        a_out_ready = 4'b1110;
        applyStimulus(2'd0, 32'h55);
        tick();
        for (int j = 0; j < 8; j++) begin
            applyStimulus(2'd2, 32'hC0 + 32'(j));
            checkOutput("iso_ready", 32'(a_in_ready), 32'h1);
            tick();
            checkOutput("iso_valid", 32'(a_out_valid), 32'h5);
            checkOutput("iso_data2", a_out_data[2], 32'hC0 + 32'(j));
            checkOutput("iso_data0", a_out_data[0], 32'h55);
        end
        a_in_valid = 1'b0;
        tick();
        checkOutput("iso_after", 32'(a_out_valid), 32'h1);

        // Illegal select on the N=3 instance
        b_in_sel   = 2'd3;
        b_in_data  = 32'h77;
        b_in_valid = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("illegal_ready", 32'(b_in_ready), 32'h0);
            tick();
            checkOutput("illegal_valid", 32'(b_out_valid), 32'h0);
        end
        checkOutput("illegal_busy", 32'(b_busy), 32'h0);
        b_in_sel = 2'd2;
        #1;
        checkOutput("legal_ready", 32'(b_in_ready), 32'h1);
        tick();
        checkOutput("legal_valid", 32'(b_out_valid), 32'h4);
        checkOutput("legal_data", b_out_data[2], 32'h77);
        b_in_valid = 1'b0;

        // Reset mid-stream with lanes 0 and 2 full
        a_out_ready = 4'b1010;
        applyStimulus(2'd2, 32'h66);
        tick();
        a_in_valid = 1'b0;
        checkOutput("prerst_valid", 32'(a_out_valid), 32'h5);
        checkOutput("prerst_data2", a_out_data[2], 32'h66);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(a_out_valid), 32'h0);
        checkOutput("rst_busy", 32'(a_busy), 32'h0);
        checkOutput("rst_data0", a_out_data[0], 32'h0);
        checkOutput("rst_data2", a_out_data[2], 32'h0);
        checkOutput("rst_b_valid", 32'(b_out_valid), 32'h0);
        tick();
        rst_n    = 1'b1;
        a_in_sel = 2'd1;
        #1;
        checkOutput("post_rst_ready", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("post_rst_valid", 32'(a_out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_param_reg.md
# demux_param_reg

Registered 1-to-N demultiplexer with valid/ready flow control: a single WIDTH-bit input stream is steered, per beat, to one of N output lanes chosen by a select field, with one holding register per lane. It is the fan-out counterpart of `mux_param`. It sits at the output side of the fetch queue, distributing fetched words to N downstream consumers (decode or issue slots) that may stall independently.

## Interface
Parameters:
- WIDTH, 32, bits per data beat
- N, 4, number of output lanes; legal range is N ≥ 2, and non-power-of-2 values are allowed
- SELW, $clog2(N), select width; localparam, not overridable

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  input beat
- in_sel  in  SELW  target lane for in_data
- in_valid  in  1  input beat present
- in_ready  out  1  block will accept the beat this cycle
- out_data  out  [WIDTH-1:0] x [N-1:0] (unpacked array)  per-lane held data
- out_valid  out  N  per-lane data valid
- out_ready  in  N  per-lane consumer accepts
- busy  out  1  OR of out_valid

## Operation
- Each lane i has a one-entry register (data_q[i], vld_q[i]); out_data[i]=data_q[i], out_valid[i]=vld_q[i].
- Drain: lane i drains in a cycle when out_valid[i] & out_ready[i].
- Ready:
  - in_ready = (in_sel < N) & (~vld_q[in_sel] | out_ready[in_sel]).
  - in_ready is combinational from in_sel, vld_q and out_ready; there is no path from in_valid.
- Accept: the beat is accepted in a cycle when in_valid & in_ready. On the next edge, data_q[in_sel] ← in_data and vld_q[in_sel] ← 1.
- Per-lane next state:
  - load only: vld ← 1, data ← in_data.
  - drain only: vld ← 0, data holds its last value.
  - drain + load in the same cycle on the same lane: vld stays 1, data ← new beat. No bubble, no loss.
  - neither: hold.
- Other lanes are unaffected by an accept on lane k. Any number of lanes may drain in the same cycle as one accept.
- Illegal select (in_sel ≥ N, possible only for non-power-of-2 N): in_ready=0, no lane changes, and the beat stalls until the source changes in_sel.
- Ordering is preserved per lane. No ordering guarantee exists across lanes.
- Once out_valid[i]=1, out_data[i] is stable until the cycle after it drains (AXI-style hold).
- Source rule: in_data and in_sel must stay stable while in_valid=1 and in_ready=0. The bench asserts this; the RTL does not check it.

## Timing
- Latency: 1 cycle from accept edge to out_valid (beat accepted in cycle t is visible in cycle t+1).
- Throughput: 1 beat/cycle aggregate. A lane under continuous out_ready sustains 1 beat/cycle.
- Reset (rst_n=0, asynchronous assert): all vld_q=0, all data_q=0, busy=0. in_ready then reflects only in_sel legality.
- Reset deasserts synchronously to clk through the codebase's standard reset synchronizer upstream. No extra internal flop stage is added.
- Reset mid-operation: held beats are discarded with no flush handshake, and out_valid drops in the same cycle reset asserts.
- busy is combinational OR of vld_q, and therefore registered-timing.

## Structure
- No shared-package typedefs are required.
- SELW is derived locally. The lane register width follows WIDTH.
- Natural sub-module: demux_lane (one-entry register slice holding data/valid with load/drain logic), instantiated N times in a generate loop.
- Top level contains only the select decode, the in_ready mux, and busy.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-stream with lanes 0 and 2 full.
  - Required: out_valid=4'b0000 and out_data all 0 immediately; busy=0.
  - Required: after release, in_sel=1 gives in_ready=1.
- Basic routing:
  - Stimulus: N=4, out_ready=4'b1111; send beats 0xA0..0xA3 with in_sel=0,1,2,3 back-to-back.
  - Required: each appears one cycle later on the matching lane only, and in_ready stays 1 throughout.
- Backpressure:
  - Stimulus: out_ready[1]=0; send 0x11 then 0x22 to lane 1.
  - Required: first is accepted; second sees in_ready=0 and stalls, with out_data[1]=0x11 held.
  - Stimulus: raise out_ready[1].
  - Required: 0x22 is accepted in that same cycle and appears the next cycle.
- Simultaneous drain+load: with lane 3 holding 0x33 and out_ready[3]=1, send 0x44 to lane 3. Required: out_valid[3] stays 1 and out_data[3]=0x44 the next cycle, with no bubble.
- Lane isolation: hold lane 0 full and stalled; stream 8 beats to lane 2 with ready. Required: all 8 delivered in order at 1 beat/cycle, and lane 0 data unchanged.
- Illegal select:
  - Stimulus: N=3 build; in_sel=3, in_valid=1.
  - Required: in_ready=0 and no out_valid change for 10 cycles.
  - Stimulus: change to in_sel=2.
  - Required: the beat is accepted.
